// File: rtl/sccb_responder.sv
// SCCB/I2C target for the OV5640 init link: decodes device address, 16-bit register
// pointer and data bytes into write strobes, and serves reads from an external register file.
module sccb_responder #(
    parameter logic [6:0]  DEV_ADDR    = 7'h3C,
    parameter int unsigned SYNC_STAGES = 2     // must be at least 2
) (
    input  logic        meg25,
    input  logic        reset,
    input  logic        scl,
    inout  wire         sda,
    output logic        wr_valid,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        rd_req,
    output logic [15:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic        busy,
    output logic        addr_nack
);

    localparam logic [3:0] StIdle    = 4'd0;
    localparam logic [3:0] StAddr    = 4'd1;
    localparam logic [3:0] StAckAddr = 4'd2;
    localparam logic [3:0] StRegHi   = 4'd3;
    localparam logic [3:0] StAckHi   = 4'd4;
    localparam logic [3:0] StRegLo   = 4'd5;
    localparam logic [3:0] StAckLo   = 4'd6;
    localparam logic [3:0] StWdata   = 4'd7;
    localparam logic [3:0] StAckData = 4'd8;
    localparam logic [3:0] StTx      = 4'd9;
    localparam logic [3:0] StMack    = 4'd10;
    localparam logic [3:0] StIgnore  = 4'd11;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, sda_rise, sda_fall;
    logic                   start_det, stop_det;

    logic [3:0]  state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  byte_in;
    logic        phase_q, phase_d;
    logic        rw_q, rw_d;
    logic [7:0]  reg_hi_q, reg_hi_d;
    logic [15:0] pointer_q, pointer_d;
    logic [6:0]  tx_q, tx_d;
    logic        oe_q, oe_d;
    logic        busy_q, busy_d;
    logic        addr_nack_q, addr_nack_d;
    logic        wr_valid_q, wr_valid_d;
    logic [15:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        rd_req_q, rd_req_d;
    logic [15:0] rd_addr_q, rd_addr_d;

    always_ff @(posedge meg25) begin
        if (!reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s    = scl_sync_q[SYNC_STAGES-1];
    assign sda_s    = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_prev_q;
    assign scl_fall = ~scl_s & scl_prev_q;
    assign sda_rise = sda_s & ~sda_prev_q;
    assign sda_fall = ~sda_s & sda_prev_q;

    // scl must be high on both samples so a coincident scl edge is never taken as START/STOP
    assign start_det = sda_fall & scl_s & scl_prev_q;
    assign stop_det  = sda_rise & scl_s & scl_prev_q;

    assign byte_in = {shift_q[6:0], sda_s};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        phase_d     = phase_q;
        rw_d        = rw_q;
        reg_hi_d    = reg_hi_q;
        pointer_d   = pointer_q;
        tx_d        = tx_q;
        oe_d        = oe_q;
        busy_d      = busy_q;
        addr_nack_d = addr_nack_q;
        wr_valid_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_req_d    = 1'b0;
        rd_addr_d   = rd_addr_q;

        if (start_det) begin
            state_d   = StAddr;
            bit_cnt_d = 3'd0;
            phase_d   = 1'b0;
            oe_d      = 1'b0;
        end else if (stop_det) begin
            state_d   = StIdle;
            bit_cnt_d = 3'd0;
            phase_d   = 1'b0;
            oe_d      = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                StAddr, StRegHi, StRegLo, StWdata: begin
                    if (scl_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            phase_d = 1'b0;
                            case (state_q)
                                StAddr: begin
                                    if (byte_in[7:1] == DEV_ADDR) begin
                                        state_d = StAckAddr;
                                        rw_d    = byte_in[0];
                                        busy_d  = 1'b1;
                                    end else begin
                                        state_d     = StIgnore;
                                        addr_nack_d = 1'b1;
                                        busy_d      = 1'b0;
                                    end
                                end
                                StRegHi: begin
                                    reg_hi_d = byte_in;
                                    state_d  = StAckHi;
                                end
                                StRegLo: begin
                                    pointer_d = {reg_hi_q, byte_in};
                                    state_d   = StAckLo;
                                end
                                default: state_d = StAckData;
                            endcase
                        end
                    end
                end

                StAckAddr: begin
                    if (scl_fall && !phase_q) begin
                        oe_d    = 1'b1;
                        phase_d = 1'b1;
                    end else if (scl_rise && phase_q && rw_q) begin
                        // ACK stays low until TX drives the first data bit on the next fall
                        rd_req_d  = 1'b1;
                        rd_addr_d = pointer_q;
                        state_d   = StTx;
                        phase_d   = 1'b0;
                    end else if (scl_fall && phase_q) begin
                        oe_d      = 1'b0;
                        phase_d   = 1'b0;
                        bit_cnt_d = 3'd0;
                        state_d   = StRegHi;
                    end
                end

                StAckHi, StAckLo, StAckData: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            oe_d    = 1'b1;
                            phase_d = 1'b1;
                        end else begin
                            oe_d      = 1'b0;
                            phase_d   = 1'b0;
                            bit_cnt_d = 3'd0;
                            case (state_q)
                                StAckHi: state_d = StRegLo;
                                StAckLo: state_d = StWdata;
                                default: begin
                                    state_d    = StWdata;
                                    wr_valid_d = 1'b1;
                                    wr_addr_d  = pointer_q;
                                    wr_data_d  = shift_q;
                                    pointer_d  = pointer_q + 16'd1;
                                end
                            endcase
                        end
                    end
                end

                StTx: begin
                    // phase_q=0 means the byte has not been loaded from rd_data yet
                    if (scl_fall) begin
                        if (!phase_q) begin
                            tx_d      = rd_data[6:0];
                            oe_d      = ~rd_data[7];
                            phase_d   = 1'b1;
                            bit_cnt_d = 3'd0;
                        end else begin
                            tx_d = {tx_q[5:0], 1'b0};
                            oe_d = ~tx_q[6];
                        end
                    end else if (scl_rise && phase_q) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = StMack;
                            phase_d = 1'b0;
                        end
                    end
                end

                StMack: begin
                    if (scl_fall && !phase_q) begin
                        oe_d    = 1'b0;
                        phase_d = 1'b1;
                    end else if (scl_rise && phase_q) begin
                        phase_d = 1'b0;
                        if (!sda_s) begin
                            pointer_d = pointer_q + 16'd1;
                            rd_req_d  = 1'b1;
                            rd_addr_d = pointer_q + 16'd1;
                            state_d   = StTx;
                        end else begin
                            oe_d    = 1'b0;
                            busy_d  = 1'b0;
                            state_d = StIgnore;
                        end
                    end
                end

                default: ;
            endcase
        end
    end

    always_ff @(posedge meg25) begin
        if (!reset) begin
            state_q     <= StIdle;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            phase_q     <= 1'b0;
            rw_q        <= 1'b0;
            reg_hi_q    <= 8'd0;
            pointer_q   <= 16'd0;
            tx_q        <= 7'd0;
            oe_q        <= 1'b0;
            busy_q      <= 1'b0;
            addr_nack_q <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= 16'd0;
            wr_data_q   <= 8'd0;
            rd_req_q    <= 1'b0;
            rd_addr_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            phase_q     <= phase_d;
            rw_q        <= rw_d;
            reg_hi_q    <= reg_hi_d;
            pointer_q   <= pointer_d;
            tx_q        <= tx_d;
            oe_q        <= oe_d;
            busy_q      <= busy_d;
            addr_nack_q <= addr_nack_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_req_q    <= rd_req_d;
            rd_addr_q   <= rd_addr_d;
        end
    end

    // Gating with reset releases the bus in the very cycle reset is asserted
    assign sda = (oe_q && reset) ? 1'b0 : 1'bz;

    assign wr_valid  = wr_valid_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign rd_req    = rd_req_q;
    assign rd_addr   = rd_addr_q;
    assign busy      = busy_q;
    assign addr_nack = addr_nack_q;

endmodule

// File: tb/tb_sccb_responder.sv
// Directed bench for sccb_responder: a bit-banged SCCB master with hand-computed expectations.
module tb_sccb_responder;

    localparam int Q = 8;  // meg25 cycles per quarter scl period

    logic        meg25;
    logic        reset;
    logic        scl;
    logic        sda_low;
    wire         sda_bus;
    logic        wr_valid;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        rd_req;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data;
    logic        busy;
    logic        addr_nack;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] wr_addr_log[$];
    logic [7:0]  wr_data_log[$];
    logic [15:0] rd_addr_log[$];

    initial meg25 = 1'b0;
    always #5 meg25 = ~meg25;

    assign sda_bus = sda_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    sccb_responder #(
        .DEV_ADDR    (7'h3C),
        .SYNC_STAGES (2)
    ) dut (
        .meg25     (meg25),
        .reset     (reset),
        .scl       (scl),
        .sda       (sda_bus),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .busy      (busy),
        .addr_nack (addr_nack)
    );

    // Register file model: read data is the low address byte XOR 0x5C
    always @(negedge meg25) begin
        if (!reset) begin
            rd_data <= 8'h00;
        end else begin
            if (wr_valid) begin
                wr_addr_log.push_back(wr_addr);
                wr_data_log.push_back(wr_data);
            end
            if (rd_req) begin
                rd_addr_log.push_back(rd_addr);
                rd_data <= rd_addr[7:0] ^ 8'h5C;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic half();
        repeat (Q) @(negedge meg25);
    endtask

    task automatic clk_bit(output logic smp);
        half();
        scl = 1'b1;
        half();
        smp = sda_bus;
        half();
        scl = 1'b0;
        half();
    endtask

    task automatic bus_start();
        sda_low = 1'b0;
        half();
        scl = 1'b1;
        half();
        sda_low = 1'b1;
        half();
        scl = 1'b0;
        half();
    endtask

    task automatic bus_stop();
        sda_low = 1'b1;
        half();
        scl = 1'b1;
        half();
        sda_low = 1'b0;
        half();
        half();
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        logic s;
        for (int i = 7; i > 7 - n; i--) begin
            sda_low = ~b[i];
            clk_bit(s);
        end
    endtask

    task automatic tx_ack(input string tag, input logic [7:0] b, input logic exp_ack);
        logic s;
        send_bits(b, 8);
        sda_low = 1'b0;
        clk_bit(s);
        check(tag, {31'd0, s === 1'b0}, {31'd0, exp_ack});
    endtask

    task automatic recv_byte(output logic [7:0] b, input logic give_ack);
        logic s;
        sda_low = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(s);
            b[i] = s;
        end
        sda_low = give_ack;
        clk_bit(s);
        sda_low = 1'b0;
    endtask

    logic [7:0] rb;

    initial begin
        reset   = 1'b0;
        scl     = 1'b1;
        sda_low = 1'b0;
        repeat (4) @(negedge meg25);
        check("rst_sda", sda_bus, 1);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_rd_req", rd_req, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_addr_nack", addr_nack, 0);
        reset = 1'b1;
        repeat (4) @(negedge meg25);

        // Single write
        bus_start();
        tx_ack("w1_ack_dev", 8'h78, 1);
        check("w1_busy", busy, 1);
        tx_ack("w1_ack_hi", 8'h30, 1);
        tx_ack("w1_ack_lo", 8'h08, 1);
        tx_ack("w1_ack_data", 8'h82, 1);
        bus_stop();
        check("w1_busy_stop", busy, 0);
        check("w1_count", wr_addr_log.size(), 1);
        check("w1_addr", wr_addr_log[0], 16'h3008);
        check("w1_data", wr_data_log[0], 8'h82);

        // Burst write
        bus_start();
        tx_ack("bw_ack_dev", 8'h78, 1);
        tx_ack("bw_ack_hi", 8'h47, 1);
        tx_ack("bw_ack_lo", 8'h40, 1);
        tx_ack("bw_ack_d0", 8'h21, 1);
        tx_ack("bw_ack_d1", 8'h22, 1);
        bus_stop();
        check("bw_count", wr_addr_log.size(), 3);
        check("bw_addr0", wr_addr_log[1], 16'h4740);
        check("bw_data0", wr_data_log[1], 8'h21);
        check("bw_addr1", wr_addr_log[2], 16'h4741);
        check("bw_data1", wr_data_log[2], 8'h22);

        // Read with repeated start
        bus_start();
        tx_ack("rd_ack_dev", 8'h78, 1);
        tx_ack("rd_ack_hi", 8'h30, 1);
        tx_ack("rd_ack_lo", 8'h0A, 1);
        bus_start();
        tx_ack("rd_ack_devr", 8'h79, 1);
        check("rd_req_count0", rd_addr_log.size(), 1);
        check("rd_addr0", rd_addr_log[0], 16'h300A);
        recv_byte(rb, 1'b1);
        check("rd_byte0", rb, 8'h56);
        check("rd_req_count1", rd_addr_log.size(), 2);
        check("rd_addr1", rd_addr_log[1], 16'h300B);
        recv_byte(rb, 1'b0);
        check("rd_byte1", rb, 8'h57);
        check("rd_nack_busy", busy, 0);
        check("rd_nack_sda", sda_bus, 1);
        check("rd_nack_no_req", rd_addr_log.size(), 2);
        bus_stop();
        check("rd_no_write", wr_addr_log.size(), 3);

        // Wrong device address, then a valid write
        bus_start();
        tx_ack("bad_no_ack", 8'h42, 0);
        check("bad_addr_nack", addr_nack, 1);
        check("bad_busy", busy, 0);
        bus_stop();
        check("bad_no_write", wr_addr_log.size(), 3);
        check("bad_no_read", rd_addr_log.size(), 2);
        bus_start();
        tx_ack("ok_ack_dev", 8'h78, 1);
        tx_ack("ok_ack_hi", 8'h12, 1);
        tx_ack("ok_ack_lo", 8'h34, 1);
        tx_ack("ok_ack_data", 8'hAB, 1);
        bus_stop();
        check("ok_count", wr_addr_log.size(), 4);
        check("ok_addr", wr_addr_log[3], 16'h1234);
        check("ok_data", wr_data_log[3], 8'hAB);
        check("ok_nack_sticky", addr_nack, 1);

        // STOP after 4 bits of a data byte
        bus_start();
        tx_ack("ps_ack_dev", 8'h78, 1);
        tx_ack("ps_ack_hi", 8'h55, 1);
        tx_ack("ps_ack_lo", 8'h66, 1);
        send_bits(8'hF0, 4);
        bus_stop();
        check("ps_no_write", wr_addr_log.size(), 4);
        check("ps_busy", busy, 0);

        // Repeated START in the middle of the low register byte
        bus_start();
        tx_ack("rs_ack_dev", 8'h78, 1);
        tx_ack("rs_ack_hi", 8'h11, 1);
        send_bits(8'h22, 3);
        bus_start();
        tx_ack("rs_ack_dev2", 8'h78, 1);
        tx_ack("rs_ack_hi2", 8'h77, 1);
        tx_ack("rs_ack_lo2", 8'h88, 1);
        tx_ack("rs_ack_data", 8'h99, 1);
        bus_stop();
        check("rs_count", wr_addr_log.size(), 5);
        check("rs_addr", wr_addr_log[4], 16'h7788);
        check("rs_data", wr_data_log[4], 8'h99);

        // STOP after only the high register byte keeps the pointer (0x7789)
        bus_start();
        tx_ack("hi_ack_dev", 8'h78, 1);
        tx_ack("hi_ack_hi", 8'h99, 1);
        bus_stop();
        bus_start();
        tx_ack("hi_ack_devr", 8'h79, 1);
        check("hi_rd_addr", rd_addr_log[2], 16'h7789);
        recv_byte(rb, 1'b0);
        check("hi_rd_byte", rb, 8'hD5);
        bus_stop();

        // Pointer wrap during a burst
        bus_start();
        tx_ack("wr_ack_dev", 8'h78, 1);
        tx_ack("wr_ack_hi", 8'hFF, 1);
        tx_ack("wr_ack_lo", 8'hFF, 1);
        tx_ack("wr_ack_d0", 8'h10, 1);
        tx_ack("wr_ack_d1", 8'h20, 1);
        bus_stop();
        check("wrap_count", wr_addr_log.size(), 7);
        check("wrap_addr0", wr_addr_log[5], 16'hFFFF);
        check("wrap_data0", wr_data_log[5], 8'h10);
        check("wrap_addr1", wr_addr_log[6], 16'h0000);
        check("wrap_data1", wr_data_log[6], 8'h20);

        // Reset while the responder drives a 0 data bit (rd_data 0x5D)
        bus_start();
        tx_ack("rr_ack_devr", 8'h79, 1);
        check("rr_rd_addr", rd_addr_log[3], 16'h0001);
        check("rr_sda_driven", sda_bus, 0);
        reset = 1'b0;
        #1;
        check("rr_sda_released", sda_bus, 1);
        @(negedge meg25);
        check("rr_busy", busy, 0);
        check("rr_rd_addr_out", rd_addr, 0);
        check("rr_wr_addr_out", wr_addr, 0);
        check("rr_wr_data_out", wr_data, 0);
        check("rr_addr_nack", addr_nack, 0);
        check("rr_sda_held", sda_bus, 1);
        reset = 1'b1;
        repeat (4) @(negedge meg25);
        scl = 1'b1;
        half();
        half();

        // Recovery after reset
        bus_start();
        tx_ack("rec_ack_dev", 8'h78, 1);
        tx_ack("rec_ack_hi", 8'h00, 1);
        tx_ack("rec_ack_lo", 8'h00, 1);
        tx_ack("rec_ack_data", 8'h5A, 1);
        bus_stop();
        check("rec_count", wr_addr_log.size(), 8);
        check("rec_addr", wr_addr_log[7], 16'h0000);
        check("rec_data", wr_data_log[7], 8'h5A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
